// File: rtl/synch_fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO: pointer decode helpers,
// address-width computation and parameter legality checks.
package synch_fifo_pkg;

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_flags_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

    // Full when the address bits match and only the wrap bit differs.
    function automatic logic ptr_full(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr,
                                      input int addr_w);
        return (wr_ptr ^ rd_ptr) == (32'd1 << addr_w);
    endfunction

    function automatic logic params_legal(input int width, input int depth, input int afull_th,
                                          input int aempty_th, input int fwft);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (aempty_th >= 1) && (aempty_th < afull_th) && (afull_th <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
module fifo_ram_2p #(
    parameter  int WIDTH  = 4,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synch_fifo_flagged.sv
// Single-clock FIFO with occupancy count, threshold flags, optional
// first-word-fall-through output and pulsed/sticky overflow and underflow reporting.
module synch_fifo_flagged
    import synch_fifo_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DEPTH     = 16,
    parameter  int AFULL_TH  = 12,
    parameter  int AEMPTY_TH = 2,
    parameter  int FWFT      = 0,
    localparam int ADDR_W    = addr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              rd_en_i,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    input  logic              err_clr_i,
    output logic              error_o,
    output logic              ovf_o,
    output logic              udf_o
);

    if (!params_legal(WIDTH, DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("synch_fifo_flagged: illegal WIDTH/DEPTH/threshold/FWFT combination");
    end

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W + 1)'(AEMPTY_TH);

    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  count;
    logic             rd_acc;
    logic             wr_acc;
    logic             ovf_ev;
    logic             udf_ev;
    logic             error_q;
    err_flags_t       err_q;
    logic [WIDTH-1:0] ram_rdata;

    assign empty_o        = ptr_empty(32'(wr_ptr), 32'(rd_ptr));
    assign full_o         = ptr_full(32'(wr_ptr), 32'(rd_ptr), ADDR_W);
    assign almost_full_o  = (count >= AF_LVL);
    assign almost_empty_o = (count <= AE_LVL);
    assign count_o        = count;

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    assign rd_acc = rd_en_i & ~empty_o;
    assign wr_acc = wr_en_i & (~full_o | rd_acc);
    assign ovf_ev = wr_en_i & ~wr_acc;
    assign udf_ev = rd_en_i & empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as err_clr_i keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
            err_q   <= '0;
        end else begin
            error_q   <= ovf_ev | udf_ev;
            err_q.ovf <= ovf_ev | (err_q.ovf & ~err_clr_i);
            err_q.udf <= udf_ev | (err_q.udf & ~err_clr_i);
        end
    end

    assign error_o = error_q;
    assign ovf_o   = err_q.ovf;
    assign udf_o   = err_q.udf;

    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (wr_acc & ~rst_i),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wdata_i),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata_o = empty_o ? '0 : ram_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= ram_rdata;
            end
        end

        assign rdata_o = rdata_q;
    end

endmodule

// File: doc/synch_fifo_flagged.md
# synch_fifo_flagged

Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO. It adds programmable almost-full and almost-empty thresholds, an occupancy count, and a first-word-fall-through (FWFT) mode. It accepts a write and a read in the same cycle when full, and reports overflow and underflow both as pulses and as sticky flags. It sits between producer and consumer blocks in the same clock domain as a general-purpose elastic buffer.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_TH, 12, almost_full_o asserts when count ≥ AFULL_TH; AEMPTY_TH < AFULL_TH ≤ DEPTH-1
- AEMPTY_TH, 2, almost_empty_o asserts when count ≤ AEMPTY_TH; 1 ≤ AEMPTY_TH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- ADDR_W (localparam), $clog2(DEPTH)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  write request
- wdata_i  in  WIDTH  write data
- rd_en_i  in  1  read request (FWFT=1: pop/acknowledge of rdata_o)
- rdata_o  out  WIDTH  read data
- full_o / empty_o  out  1  occupancy == DEPTH / == 0
- almost_full_o / almost_empty_o  out  1  threshold flags
- count_o  out  ADDR_W+1  current occupancy, 0..DEPTH
- err_clr_i  in  1  clears sticky error flags
- error_o  out  1  one-cycle pulse, registered, for any rejected request
- ovf_o / udf_o  out  1  sticky overflow / underflow flags

## Operation
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide. The low bits address memory and the MSB is the wrap/toggle bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
- rd_acc = rd_en_i & !empty_o.
- wr_acc = wr_en_i & (!full_o | rd_acc). A write to a full FIFO succeeds only together with an accepted read.
- A write with wr_en_i & !wr_acc is an overflow: data is dropped and state is unchanged.
- A read with rd_en_i & empty_o is an underflow: pointers are unchanged and rdata_o holds its value.
- count_o update (modulo-free, never exceeds DEPTH):
  - +1 on wr_acc only
  - −1 on rd_acc only
  - unchanged when both or neither occur
- Pointers wrap naturally through DEPTH-1 → 0 with the MSB toggling.
- full_o, empty_o, almost_* are decoded from the registered pointers and count, so no combinational path runs from the enables to the flags.
- Read data:
  - FWFT=0: rdata_o is a register loaded with mem[rd_ptr] on rd_acc. It is valid the cycle after the read and holds otherwise.
  - FWFT=1: rdata_o = mem[rd_ptr] whenever !empty_o, and 0 when empty. rd_en_i pops the entry.
- Errors:
  - error_o pulses for 1 cycle following any overflow or underflow.
  - ovf_o / udf_o set on the respective event and hold until err_clr_i or rst_i.
  - If a new event coincides with err_clr_i, set wins.
- Reset (including mid-operation, in any cycle):
  - Pointers and count go to 0; contents are discarded (memory itself is not cleared).
  - Outputs: empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, count_o=0, rdata_o=0, error_o=0, ovf_o=0, udf_o=0.
  - Requests presented during the reset cycle are ignored and flag no error.

## Timing
- Write latency to visibility:
  - A word written at edge N makes empty_o fall after edge N.
  - FWFT=1: the word is on rdata_o from edge N.
  - FWFT=0: the word is readable by rd_en_i in cycle N+1, and data appears after the following edge.
- Flags and count reflect all accepted operations up to and including the last edge. They have zero extra latency beyond the register.
- Throughput: one write and one read per cycle sustained, including at full and at empty (write side).
- Simultaneous read and write on an empty FIFO: the read is an underflow, the write is accepted, and the count becomes 1.

## Structure
- Shared package/header synch_fifo_pkg:
  - ADDR_W computation
  - pointer full/empty compare functions
  - parameter-legality checks (elaboration-time $error on illegal DEPTH or thresholds)
- Sub-module fifo_ram_2p (WIDTH, DEPTH): synchronous write port and asynchronous read port.
- Top level: pointer/count control, flag decode, read register for FWFT=0, error logic. Estimated 150–250 lines total.

## Test plan
All scenarios use WIDTH=4, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2.
- Reset then idle → empty_o=1, almost_empty_o=1, count_o=0, rdata_o=0, all error flags 0.
- FWFT=0, write 16 words 0x1..0xF,0x0 back-to-back:
  - almost_empty_o falls at count 3
  - almost_full_o rises at count 12
  - full_o=1 at 16
  - a 17th write → error_o pulse, ovf_o=1, count stays 16
- Read all 16 words:
  - data returns in order 0x1..0x0, each one cycle after rd_en_i
  - empty_o=1 at the end
  - one extra read → udf_o=1, rdata_o holds 0x0
- Full FIFO, simultaneous write 0xA and read:
  - read returns the oldest word, 0xA is accepted, count stays 16, no error
  - 30 mixed operations verify pointer wrap against a scoreboard
- FWFT=1: a single write of 0x5 shows 0x5 on rdata_o after one edge with no rd_en_i. Asserting rd_en_i pops it; empty_o=1 and rdata_o=0.
- Reset asserted with count=7 and both enables high → next cycle count_o=0, empty_o=1, no error. Assert err_clr_i after an overflow → ovf_o clears next cycle.
